// File: rtl/rv_iter_alu_if.sv
// rv_iter_alu_if: request/response bundle between the control FSM and the
// iterative execute unit.
//   in_valid/in_ready      : request handshake (requester -> ALU)
//   op, a, b               : op code {funct7[0], funct7[5], funct3} and operands
//   out_valid/out_ready    : result handshake (ALU -> consumer)
//   result, err            : result value and illegal-op flag, qualified by out_valid
// Modports: master = requester/consumer side, slave = the ALU.
interface rv_iter_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/rv_iter_alu.sv
// rv_iter_alu: XLEN-wide RV32I integer execute unit for the multicycle core.
// Logic/arithmetic ops complete in one cycle, shifts are done iteratively
// SHIFT_STEP bits per cycle, and an optional shift-add multiplier handles MUL.
// Ports:
//   Clock   : clock, all state changes on posedge
//   resetn  : synchronous, active-low reset (aborts any operation in flight)
//   bus     : rv_iter_alu_if.slave (request and result handshakes, see interface)
// Parameters:
//   XLEN       : datapath width, power of 2, >= 8
//   SHIFT_STEP : bits shifted per cycle, power of 2, <= XLEN
// Optional feature:
//   RV_ITER_ALU_MUL_EN : when defined, op 10000 is MUL (low XLEN bits of a*b,
//                        XLEN iteration cycles); when undefined op 10000 is illegal.
module rv_iter_alu #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic         Clock,
    input  logic         resetn,
    rv_iter_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    // Counter must hold XLEN itself (MUL iteration count), hence one extra bit.
    localparam int CW  = SHW + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
`ifdef RV_ITER_ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b10000;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef RV_ITER_ALU_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            err_r;
    logic [4:0]      op_r;
    logic [XLEN-1:0] work_r;   // shift operand, or MUL accumulator
    logic [CW-1:0]   cnt_r;    // remaining shift bits, or remaining MUL iterations
`ifdef RV_ITER_ALU_MUL_EN
    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] acc_next_s;
`endif

    logic [SHW-1:0]  shamt_s;
    logic            is_shift_s;
    logic [CW-1:0]   step_s;
    logic [XLEN-1:0] shifted_s;

    // Single-cycle ops; returns {err, result}. Shift and MUL codes never reach
    // this function, so anything not listed here is an illegal op.
    function automatic logic [XLEN:0] alu_single(input logic [4:0] o,
                                                 input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
        logic [XLEN:0] r;
        r = {(XLEN+1){1'b0}};
        case (o)
            OP_ADD:  r = {1'b0, x + y};
            OP_SUB:  r = {1'b0, x - y};
            OP_SLT:  r = {1'b0, {(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {1'b0, {(XLEN-1){1'b0}}, (x < y)};
            OP_XOR:  r = {1'b0, x ^ y};
            OP_OR:   r = {1'b0, x | y};
            OP_AND:  r = {1'b0, x & y};
            default: r = {1'b1, {XLEN{1'b0}}};
        endcase
        return r;
    endfunction

    // Request decode: shift amount and shift-op detection on the live inputs.
    always_comb begin
        shamt_s    = bus.b[SHW-1:0];
        is_shift_s = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    end

    // Iterative shifter step: move by min(SHIFT_STEP, remaining) bits.
    // SRA keeps replicating the MSB, which is the sign captured at accept.
    always_comb begin
        step_s    = (cnt_r < CW'(SHIFT_STEP)) ? cnt_r : CW'(SHIFT_STEP);
        shifted_s = work_r;
        case (op_r)
            OP_SLL:  shifted_s = work_r << step_s;
            OP_SRL:  shifted_s = work_r >> step_s;
            OP_SRA:  shifted_s = XLEN'($signed(work_r) >>> step_s);
            default: shifted_s = work_r;
        endcase
    end

`ifdef RV_ITER_ALU_MUL_EN
    // Shift-add step: add the current multiplicand when the low multiplier bit is set.
    always_comb begin
        acc_next_s = work_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge Clock) begin
        if (!resetn) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            err_r       <= 1'b0;
            op_r        <= 5'b00000;
            work_r      <= {XLEN{1'b0}};
            cnt_r       <= {CW{1'b0}};
`ifdef RV_ITER_ALU_MUL_EN
            mcand_r     <= {XLEN{1'b0}};
            mplier_r    <= {XLEN{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_r       <= bus.op;
                        in_ready_r <= 1'b0;
                        if (is_shift_s) begin
                            if (shamt_s == {SHW{1'b0}}) begin
                                result_r    <= bus.a;
                                err_r       <= 1'b0;
                                out_valid_r <= 1'b1;
                                state_r     <= S_DONE;
                            end else begin
                                work_r  <= bus.a;
                                cnt_r   <= CW'(shamt_s);
                                state_r <= S_SHIFT;
                            end
                        end
`ifdef RV_ITER_ALU_MUL_EN
                        else if (bus.op == OP_MUL) begin
                            work_r   <= {XLEN{1'b0}};
                            mcand_r  <= bus.a;
                            mplier_r <= bus.b;
                            cnt_r    <= CW'(XLEN);
                            state_r  <= S_MUL;
                        end
`endif
                        else begin
                            {err_r, result_r} <= alu_single(bus.op, bus.a, bus.b);
                            out_valid_r       <= 1'b1;
                            state_r           <= S_DONE;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    work_r <= shifted_s;
                    cnt_r  <= cnt_r - step_s;
                    if (cnt_r == step_s) begin
                        result_r    <= shifted_s;
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        state_r <= S_SHIFT;
                    end
                end
`ifdef RV_ITER_ALU_MUL_EN
                S_MUL: begin
                    work_r   <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                        result_r    <= acc_next_s;
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        state_r <= S_MUL;
                    end
                end
`endif
                S_DONE: begin
                    // result/err stay put until consumed; no accept on the handoff edge.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_rv_iter_alu.sv
// tb_rv_iter_alu: self-checking bench for rv_iter_alu (XLEN=32, SHIFT_STEP=1).
// Directed vector table, hand-written backpressure and reset-abort sequences,
// then randomized ops checked against an arithmetic reference model.
module tb_rv_iter_alu;
    localparam int XLEN = 32;
    localparam int STEP = 1;

    logic Clock = 1'b0;
    logic resetn;
    always #5 Clock = ~Clock;

    rv_iter_alu_if #(.XLEN(XLEN)) bus ();

    rv_iter_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .Clock (Clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int shift_lat(input int sh);
        return (sh == 0) ? 1 : 1 + (sh + STEP - 1) / STEP;
    endfunction

    // Reference model: plain arithmetic on the op-code meaning.
    function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic e, output int lat);
        int sh;
        sh  = int'(y[4:0]);
        r   = 32'd0;
        e   = 1'b0;
        lat = 1;
        case (o)
            5'b00000: r = x + y;
            5'b01000: r = x - y;
            5'b00001: begin r = x << sh; lat = shift_lat(sh); end
            5'b00101: begin r = x >> sh; lat = shift_lat(sh); end
            5'b01101: begin r = $signed(x) >>> sh; lat = shift_lat(sh); end
            5'b00010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'b00011: r = (x < y) ? 32'd1 : 32'd0;
            5'b00100: r = x ^ y;
            5'b00110: r = x | y;
            5'b00111: r = x & y;
`ifdef RV_ITER_ALU_MUL_EN
            5'b10000: begin r = x * y; lat = 1 + XLEN; end
`endif
            default:  e = 1'b1;
        endcase
    endfunction

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clock); #1;
        end
        if (!ok) begin
            nvec++;
            nmis++;
            $display("FAIL %s idle-wait: in_ready stayed 0, expected 1", tag);
        end
    endtask

    // One transaction; hold = cycles of out_ready low once the result shows.
    task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int hold,
                         output logic [31:0] r, output logic e, output int lat);
        bit got;
        wait_idle(tag);
        @(negedge Clock);
        bus.in_valid  = 1'b1;
        bus.op        = o;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = (hold == 0);
        @(posedge Clock); #1;
        // Scramble inputs after accept: the unit must have captured them.
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        got = 1'b0;
        lat = 0;
        r   = 32'd0;
        e   = 1'b0;
        for (int i = 1; i <= XLEN + 40; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                lat = i;
                r   = bus.result;
                e   = bus.err;
                break;
            end
            @(posedge Clock); #1;
        end
        if (!got) begin
            nvec++;
            nmis++;
            $display("FAIL %s timeout: out_valid never rose, expected a result", tag);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge Clock); #1;
            chk({tag, " hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, " hold_result"}, bus.result, r);
        end
        bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        chk({tag, " post_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " post_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    logic [4:0] codes [13] = '{5'b00000, 5'b01000, 5'b00001, 5'b00101, 5'b01101,
                               5'b00010, 5'b00011, 5'b00100, 5'b00110, 5'b00111,
                               5'b10000, 5'b01001, 5'b11111};

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, er;
        logic        e, ee;
        int          lat, el, seen, hold;
        logic [4:0]  o;
        logic [31:0] x, y;

        bus.in_valid  = 1'b0;
        bus.op        = 5'b00000;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b1;
        resetn        = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset err", {31'd0, bus.err}, 32'd0);
        @(negedge Clock);
        resetn = 1'b1;
        @(posedge Clock); #1;

        // Directed vectors.
        vecs.push_back('{5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1});
        vecs.push_back('{5'b01000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1});
        vecs.push_back('{5'b00010, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 1});
        vecs.push_back('{5'b00011, 32'hFFFFFFFE, 32'd1, 32'd0, 1'b0, 1});
        vecs.push_back('{5'b01101, 32'h80000000, 32'h3F, 32'hFFFFFFFF, 1'b0, 1 + (31 + STEP - 1) / STEP});
        vecs.push_back('{5'b01101, 32'h80000000, 32'h20, 32'h80000000, 1'b0, 1});
        vecs.push_back('{5'b00001, 32'd1, 32'd4, 32'h10, 1'b0, 1 + (4 + STEP - 1) / STEP});
        vecs.push_back('{5'b00101, 32'hF0000000, 32'd4, 32'h0F000000, 1'b0, 1 + (4 + STEP - 1) / STEP});
        vecs.push_back('{5'b00100, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1});
        vecs.push_back('{5'b00110, 32'hA0000005, 32'h0000F000, 32'hA000F005, 1'b0, 1});
        vecs.push_back('{5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1});
        vecs.push_back('{5'b11111, 32'h12345678, 32'h1, 32'h0, 1'b1, 1});
        vecs.push_back('{5'b01001, 32'h12345678, 32'h1, 32'h0, 1'b1, 1});
`ifdef RV_ITER_ALU_MUL_EN
        vecs.push_back('{5'b10000, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1 + XLEN});
`else
        vecs.push_back('{5'b10000, 32'h0000FFFF, 32'h00010001, 32'h0, 1'b1, 1});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, r, e, lat);
            chk($sformatf("vec%0d result", i), r, vecs[i].res);
            chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: SLL 1<<4 held 5 cycles while a second request is offered.
        wait_idle("bp");
        @(negedge Clock);
        bus.in_valid = 1'b1; bus.op = 5'b00001; bus.a = 32'd1; bus.b = 32'd4; bus.out_ready = 1'b0;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.out_valid) begin lat = i; break; end
            @(posedge Clock); #1;
        end
        chk("bp latency", 32'(lat), 32'(shift_lat(4)));
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            bus.in_valid = 1'b1; bus.op = 5'b00000; bus.a = 32'd7; bus.b = 32'd7;
            @(posedge Clock); #1;
            chk("bp valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp result", bus.result, 32'h10);
            chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge Clock);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        chk("bp release valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp release ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp idle result", bus.result, 32'h10);
        seen = 0;
        repeat (3) begin
            @(posedge Clock); #1;
            if (bus.out_valid) seen++;
        end
        chk("bp not queued", 32'(seen), 32'd0);

        // Reset in the middle of a 20-bit shift aborts it.
        wait_idle("rst");
        @(negedge Clock);
        bus.in_valid = 1'b1; bus.op = 5'b00101; bus.a = 32'hFFFFFFFF; bus.b = 32'd20; bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge Clock);
        @(negedge Clock); resetn = 1'b0;
        @(negedge Clock); resetn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge Clock); #1;
            if (bus.out_valid) seen++;
        end
        chk("rst no result", 32'(seen), 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst result", bus.result, 32'd0);
        chk("rst err", {31'd0, bus.err}, 32'd0);

        // Randomized ops against the model, with occasional backpressure.
        for (int n = 0; n < 300; n++) begin
            o = codes[$urandom_range(0, 12)];
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = {27'd0, 5'($urandom_range(0, 1))};
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model(o, x, y, er, ee, el);
            do_op($sformatf("rnd%0d", n), o, x, y, hold, r, e, lat);
            chk($sformatf("rnd%0d op%05b result", n, o), r, er);
            chk($sformatf("rnd%0d op%05b err", n, o), {31'd0, e}, {31'd0, ee});
            chk($sformatf("rnd%0d op%05b latency", n, o), 32'(lat), 32'(el));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/rv_iter_alu.md
Name: rv_iter_alu

Overview:
- Parametrised XLEN-wide RV32I integer execute unit for the multicycle RISC-V core. It replaces the single-cycle add/sub ALU in the datapath.
- Takes operands and an op code from the control FSM in its exec stage over a valid/ready handshake. Returns the result over a second valid/ready handshake.
- Logic and arithmetic ops take one cycle. Shifts use an iterative SHIFT_STEP-bit-per-cycle shifter. An optional iterative multiplier can be compiled in.

Parameters:
- XLEN, 32, datapath width in bits; must be a power of 2, minimum 8.
- SHIFT_STEP, 1, bits shifted per cycle; must be a power of 2 and no greater than XLEN.

Ports:
- Clock  input  1  clock; all state updates on posedge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op  input  5  {funct7[0], funct7[5], funct3}.
- a  input  XLEN  operand rs1.
- b  input  XLEN  operand rs2 or sign-extended immediate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  result value.
- err  output  1  qualified by out_valid; the op was illegal.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; err=0. Reset mid-operation aborts the operation; no result is produced.
- Accept: a request is accepted on a posedge with in_valid & in_ready. a, b and op are captured; the unit does not look at them again until the next accept.
- Op encodings:
  - 00000 ADD, 01000 SUB (two's complement, carry dropped).
  - 00001 SLL, 00101 SRL, 01101 SRA.
  - 00010 SLT (signed), 00011 SLTU; result is 0 or 1, zero-extended.
  - 00100 XOR, 00110 OR, 00111 AND.
  - 10000 MUL (only with the optional feature).
  - Any other code is illegal: result=0, err=1, latency 1.
- Shift amount = b[$clog2(XLEN)-1:0]; upper bits of b are ignored.
- FSM states and transitions:
  - IDLE: accept of a single-cycle op -> DONE.
  - IDLE: accept of a shift with shamt=0 -> DONE, result=a.
  - IDLE: accept of a shift with shamt!=0 -> SHIFT.
  - IDLE: accept of MUL -> MUL.
  - SHIFT: each cycle shifts the working register by min(SHIFT_STEP, remaining) and decrements the remaining count. SRA fills with the captured sign bit. When remaining reaches 0 -> DONE.
  - MUL: shift-add, one multiplier bit per cycle, for XLEN cycles -> DONE.
  - DONE: out_valid=1; result and err held stable. On out_ready -> IDLE.
- in_ready is 0 in DONE, so there is no same-cycle accept on handoff. Peak throughput is one single-cycle op per 2 cycles.
- Latency, counted from the accept edge to the edge where out_valid is first seen high:
  - Single-cycle op: 1.
  - Shift: 1 + ceil(shamt/SHIFT_STEP).
  - MUL: 1 + XLEN.
- in_valid while busy is ignored and is not queued. The requester must hold in_valid until in_ready.
- out_valid and out_ready both high on the same edge: the result is consumed and state=IDLE next cycle.
- result is registered; it keeps its last value in IDLE.

Optional Feature:
- Macro: RV_ITER_ALU_MUL_EN.
- Defined: op 10000 = MUL. Result is the low XLEN bits of a*b; signed and unsigned give the same low half. err=0.
- Undefined: the MUL state and datapath are absent. op 10000 is illegal: result=0, err=1, latency 1.

Test Plan:
- XLEN=32; ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept; result=0x00000000, err=0; in_ready high the following cycle.
- SUB a=5, b=7 -> 0xFFFFFFFE. SLT a=0xFFFFFFFE, b=1 -> 1. SLTU with the same operands -> 0. All latency 1.
- SRA a=0x80000000, b=0x0000003F (shamt 31), SHIFT_STEP=1:
  - result=0xFFFFFFFF, out_valid exactly 32 cycles after accept.
  - Repeat with SHIFT_STEP=4: latency 9.
  - shamt 0 -> result=a, latency 1.
- Backpressure: SLL a=1, b=4, out_ready=0 for 5 cycles:
  - result=0x10 and out_valid held stable; in_ready=0 and a second in_valid is ignored.
  - out_ready=1 -> IDLE next cycle.
- resetn=0 for one cycle during SHIFT with shamt 20 -> out_valid never rises for that op, in_ready=1, result=0.
- op=10000, a=0xFFFF, b=0x10001:
  - With RV_ITER_ALU_MUL_EN: result=0xFFFFFFFF, latency 33.
  - Without it: result=0, err=1, latency 1.
